// File: rtl/modcounter.sv
// modcounter: modulo-T up/down counter with an enable prescaler, synchronous
// clear/load, wrap or saturate at the boundaries, and a registered one-cycle
// terminal-count pulse (tc) for cascading counters.
//
// Optional feature: define MODCOUNTER_COMPARE_EN to add the cmp_val input and
// the registered cmp_hit output (high exactly while count == cmp_val).
//
// Priority on each rising edge: rst > clr > load > step.
module modcounter #(
  parameter int T        = 1024,
  parameter int W        = 10,
  parameter int PRESCALE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dir,
  input  logic         sat,
`ifdef MODCOUNTER_COMPARE_EN
  input  logic [W-1:0] cmp_val,
  output logic         cmp_hit,
`endif
  output logic [W-1:0] count,
  output logic         tc
);

  // Reject configurations where the count range does not fit or is degenerate.
  generate
    if ((T < 2) || (PRESCALE < 1) || (W < 1) || ((W < 31) && ((1 << W) < T))) begin : g_bad_params
      $error("modcounter: illegal parameters (need T >= 2, PRESCALE >= 1, 2**W >= T)");
    end
  endgenerate

  localparam logic [W-1:0] CNT_MAX  = W'(T - 1);
  localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};

  // Load values beyond the modulus are pinned to the top of the range.
  function automatic logic [W-1:0] clamp_load(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v > CNT_MAX) begin
      r = CNT_MAX;
    end else begin
      r = v;
    end
    return r;
  endfunction

  logic         step_s;
  logic [W-1:0] count_nxt_s;
  logic         tc_nxt_s;

  // ---------------------------------------------------------------------------
  // Prescaler: a step fires on every PRESCALE-th accepted ena pulse. Load does
  // not touch it, so ena during a load still counts toward the next step.
  // ---------------------------------------------------------------------------
  generate
    if (PRESCALE > 1) begin : g_pre
      localparam int             PW     = $clog2(PRESCALE);
      localparam logic [PW-1:0]  P_LAST = PW'(PRESCALE - 1);
      localparam logic [PW-1:0]  P_ZERO = {PW{1'b0}};
      localparam logic [PW-1:0]  P_ONE  = {{(PW-1){1'b0}}, 1'b1};

      logic [PW-1:0] p_r;
      logic [PW-1:0] p_nxt_s;

      // Next prescaler value: clear discards progress, ena advances/rolls over.
      always_comb begin
        p_nxt_s = p_r;
        if (clr) begin
          p_nxt_s = P_ZERO;
        end else if (ena) begin
          if (p_r == P_LAST) begin
            p_nxt_s = P_ZERO;
          end else begin
            p_nxt_s = p_r + P_ONE;
          end
        end else begin
          p_nxt_s = p_r;
        end
      end

      // Prescaler register with synchronous reset.
      always_ff @(posedge clk) begin
        if (rst) begin
          p_r <= P_ZERO;
        end else begin
          p_r <= p_nxt_s;
        end
      end

      assign step_s = ena && (p_r == P_LAST);
    end else begin : g_nopre
      assign step_s = ena;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Next count and terminal-count pulse. tc flags any step taken from the
  // terminal value, so in saturate mode every blocked step re-pulses it.
  // ---------------------------------------------------------------------------
  always_comb begin
    count_nxt_s = count;
    tc_nxt_s    = 1'b0;
    if (clr) begin
      count_nxt_s = CNT_ZERO;
      tc_nxt_s    = 1'b0;
    end else if (load) begin
      count_nxt_s = clamp_load(load_val);
      tc_nxt_s    = 1'b0;
    end else if (step_s) begin
      if (dir) begin
        if (count == CNT_MAX) begin
          tc_nxt_s = 1'b1;
          if (sat) begin
            count_nxt_s = CNT_MAX;
          end else begin
            count_nxt_s = CNT_ZERO;
          end
        end else begin
          count_nxt_s = count + CNT_ONE;
        end
      end else begin
        if (count == CNT_ZERO) begin
          tc_nxt_s = 1'b1;
          if (sat) begin
            count_nxt_s = CNT_ZERO;
          end else begin
            count_nxt_s = CNT_MAX;
          end
        end else begin
          count_nxt_s = count - CNT_ONE;
        end
      end
    end else begin
      count_nxt_s = count;
      tc_nxt_s    = 1'b0;
    end
  end

  // Output registers for count and tc.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= CNT_ZERO;
      tc    <= 1'b0;
    end else begin
      count <= count_nxt_s;
      tc    <= tc_nxt_s;
    end
  end

`ifdef MODCOUNTER_COMPARE_EN
  // Compare against the value count is about to take, so cmp_hit lines up
  // with the cycles in which count equals cmp_val.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_hit <= (cmp_val == CNT_ZERO);
    end else begin
      cmp_hit <= (count_nxt_s == cmp_val);
    end
  end
`endif

endmodule

// File: tb/tb_modcounter.sv
// Self-checking bench for modcounter: three instances (T=10/P=1, T=10/P=3,
// T=7/P=4) share stimulus; a reference model checks every cycle, and
// directed phases add fixed expectations from the test plan.
module tb_modcounter;

  logic       clk = 1'b0;
  logic       rst, ena, clr, load, dir, sat;
  logic [3:0] load_val;
  logic [3:0] count1, count3;
  logic [2:0] count4;
  logic       tc1, tc3, tc4;
`ifdef MODCOUNTER_COMPARE_EN
  logic [3:0] cmp_val;
  logic       hit1, hit3, hit4;
  logic       dh [3];
  int         m_hit [3];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state per instance.
  int mt [3] = '{10, 10, 7};
  int mp [3] = '{1, 3, 4};
  int m_count [3];
  int m_p [3];
  int m_tc [3];

  logic [3:0] dc [3];
  logic       dt [3];

  always #5 clk = ~clk;

  modcounter #(.T(10), .W(4), .PRESCALE(1)) u_p1 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat),
`ifdef MODCOUNTER_COMPARE_EN
    .cmp_val(cmp_val), .cmp_hit(hit1),
`endif
    .count(count1), .tc(tc1));

  modcounter #(.T(10), .W(4), .PRESCALE(3)) u_p3 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .sat(sat),
`ifdef MODCOUNTER_COMPARE_EN
    .cmp_val(cmp_val), .cmp_hit(hit3),
`endif
    .count(count3), .tc(tc3));

  modcounter #(.T(7), .W(3), .PRESCALE(4)) u_p4 (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .load(load), .load_val(load_val[2:0]),
    .dir(dir), .sat(sat),
`ifdef MODCOUNTER_COMPARE_EN
    .cmp_val(cmp_val[2:0]), .cmp_hit(hit4),
`endif
    .count(count4), .tc(tc4));

  assign dc[0] = count1;
  assign dc[1] = count3;
  assign dc[2] = {1'b0, count4};
  assign dt[0] = tc1;
  assign dt[1] = tc3;
  assign dt[2] = tc4;
`ifdef MODCOUNTER_COMPARE_EN
  assign dh[0] = hit1;
  assign dh[1] = hit3;
  assign dh[2] = hit4;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance the reference model by one clock edge using the inputs present now.
  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      int  t;
      int  lv;
      int  cv;
      bit  fire;
      t    = mt[i];
      lv   = (i == 2) ? int'(load_val[2:0]) : int'(load_val);
      fire = 1'b0;
      if (rst) begin
        m_count[i] = 0; m_p[i] = 0; m_tc[i] = 0;
      end else if (clr) begin
        m_count[i] = 0; m_p[i] = 0; m_tc[i] = 0;
      end else begin
        if (ena) begin
          m_p[i] = m_p[i] + 1;
          if (m_p[i] == mp[i]) begin
            m_p[i] = 0;
            fire   = 1'b1;
          end
        end
        m_tc[i] = 0;
        if (load) begin
          m_count[i] = (lv < t) ? lv : t - 1;
        end else if (fire) begin
          if (dir) begin
            if (m_count[i] == t - 1) m_tc[i] = 1;
            if (!(sat && m_count[i] == t - 1)) m_count[i] = (m_count[i] + 1) % t;
          end else begin
            if (m_count[i] == 0) m_tc[i] = 1;
            if (!(sat && m_count[i] == 0)) m_count[i] = (m_count[i] + t - 1) % t;
          end
        end
      end
`ifdef MODCOUNTER_COMPARE_EN
      cv = (i == 2) ? int'(cmp_val[2:0]) : int'(cmp_val);
      m_hit[i] = (m_count[i] == cv) ? 1 : 0;
`else
      cv = 0;
`endif
    end
  endtask

  // One clock: model update at the edge, then compare all instances 1 ns later.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_count[%0d]", i), {28'd0, dc[i]}, 32'(m_count[i]));
      check($sformatf("model_tc[%0d]", i), {31'd0, dt[i]}, 32'(m_tc[i]));
`ifdef MODCOUNTER_COMPARE_EN
      check($sformatf("model_hit[%0d]", i), {31'd0, dh[i]}, 32'(m_hit[i]));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; clr = 1'b0; load = 1'b1; load_val = 4'd5;
    dir = 1'b1; sat = 1'b0;
`ifdef MODCOUNTER_COMPARE_EN
    cmp_val = 4'd0;
`endif
    for (int i = 0; i < 3; i++) begin
      m_count[i] = 0; m_p[i] = 0; m_tc[i] = 0;
`ifdef MODCOUNTER_COMPARE_EN
      m_hit[i] = 1;
`endif
    end

    // Reset held for 2 cycles with ena/load active.
    tick(); tick();
    rst = 1'b0; ena = 1'b0; load = 1'b0;
    tick();
    check("reset_count", {28'd0, count1}, 32'd0);
    check("reset_tc", {31'd0, tc1}, 32'd0);

    // Wrap up, T=10, PRESCALE=1.
    dir = 1'b1; sat = 1'b0; ena = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("wrap_count", {28'd0, count1}, 32'(k % 10));
      check("wrap_tc", {31'd0, tc1}, (k == 10) ? 32'd1 : 32'd0);
    end

    // Saturate down with prescale 3, starting from 1.
    ena = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; load = 1'b1; load_val = 4'd1; tick();
    load = 1'b0; dir = 1'b0; sat = 1'b1; ena = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("satdn_count", {28'd0, count3}, (k >= 3) ? 32'd0 : 32'd1);
      check("satdn_tc", {31'd0, tc3}, ((k % 3 == 0) && (k >= 6)) ? 32'd1 : 32'd0);
    end

    // Priority (clr over load) and load clamp.
    ena = 1'b0; clr = 1'b1; load = 1'b1; load_val = 4'd7; tick();
    check("prio_clr_count", {28'd0, count1}, 32'd0);
    check("prio_clr_count4", {29'd0, count4}, 32'd0);
    clr = 1'b0; load = 1'b1; load_val = 4'd15; tick();
    check("clamp_count", {28'd0, count1}, 32'd9);
    check("clamp_count4", {29'd0, count4}, 32'd6);
    load = 1'b0; ena = 1'b1; dir = 1'b1; sat = 1'b0; tick();
    check("clamp_wrap_count", {28'd0, count1}, 32'd0);
    check("clamp_wrap_tc", {31'd0, tc1}, 32'd1);

    // Prescaler clear discards partial progress (PRESCALE=4 instance).
    ena = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; ena = 1'b1; tick(); tick();
    check("pre_partial_count4", {29'd0, count4}, 32'd0);
    ena = 1'b0; clr = 1'b1; tick();
    clr = 1'b0; ena = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("pre_clear_count4", {29'd0, count4}, (k == 4) ? 32'd1 : 32'd0);
    end

`ifdef MODCOUNTER_COMPARE_EN
    // Compare output while counting up from 0.
    cmp_val = 4'd3; ena = 1'b0; clr = 1'b1; tick();
    check("cmp_after_clr", {31'd0, hit1}, 32'd0);
    clr = 1'b0; ena = 1'b1; dir = 1'b1; sat = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("cmp_hit", {31'd0, hit1}, ((k % 10) == 3) ? 32'd1 : 32'd0);
    end
`endif

    // Randomised stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom_range(0, 99) < 2);
      clr      = ($urandom_range(0, 99) < 5);
      load     = ($urandom_range(0, 99) < 8);
      ena      = ($urandom_range(0, 99) < 70);
      dir      = 1'($urandom_range(0, 1));
      sat      = 1'($urandom_range(0, 1));
      load_val = 4'($urandom_range(0, 15));
`ifdef MODCOUNTER_COMPARE_EN
      if ($urandom_range(0, 9) == 0) cmp_val = 4'($urandom_range(0, 15));
`endif
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
